// File: rtl/sw_run_ctrl.sv
// sw_run_ctrl: start/stop/clear run controller and tick timebase for the
// stopwatch seconds digit. Debounces two active-low push-buttons, runs an
// IDLE/RUN/PAUSE FSM and drives a phase-preserving prescaler.
//
// Ports (sw_run_ctrl):
//   CLK      system clock, all logic on posedge
//   RST      synchronous active-low reset
//   KEY_SS   start/stop button, asynchronous, 0 = pressed
//   KEY_CLR  clear button, asynchronous, 0 = pressed
//   EN_TICK  one-clock count-enable to the digit counter (decoded from registers)
//   CLR_OUT  one-clock registered clear pulse to the digit counter
//   RUNNING  level, 1 while the FSM is in RUN
//
// Ports (sw_key_cond):
//   clk, rst_n  clock and synchronous active-low reset
//   key         raw asynchronous active-low button
//   press       registered one-clock pulse after the debounced level falls

// Per-key synchronizer, debouncer and press-edge detector.
module sw_key_cond #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int unsigned DW = $clog2(DB_CYCLES);

  logic [1:0]    sync;
  logic          db;
  logic          db_prev;
  logic [DW-1:0] stab;

  // Stability counter only advances while the synchronized key disagrees
  // with the debounced level; any agreement restarts the qualification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      db      <= 1'b1;
      db_prev <= 1'b1;
      stab    <= '0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], key};
      db_prev <= db;
      press   <= db_prev & ~db;
      if (sync[1] == db) begin
        stab <= '0;
      end else if (stab == DW'(DB_CYCLES - 1)) begin
        db   <= sync[1];
        stab <= '0;
      end else begin
        stab <= stab + DW'(1);
      end
    end
  end

endmodule

// Run FSM and prescaler.
module sw_run_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_SS,
  input  logic KEY_CLR,
  output logic EN_TICK,
  output logic CLR_OUT,
  output logic RUNNING
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ss_press;
  logic          clr_press;
  logic          at_top;

  sw_key_cond #(.DB_CYCLES(DB_CYCLES)) u_key_ss (
    .clk   (CLK),
    .rst_n (RST),
    .key   (KEY_SS),
    .press (ss_press)
  );

  sw_key_cond #(.DB_CYCLES(DB_CYCLES)) u_key_clr (
    .clk   (CLK),
    .rst_n (RST),
    .key   (KEY_CLR),
    .press (clr_press)
  );

  assign at_top = (cnt_q == CW'(TICK_DIV - 1));

  // State, prescaler and clear-pulse registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      CLR_OUT <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      CLR_OUT <= clr_press;
    end
  end

  // Next state and next prescaler value; CLR takes priority over SS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE:    cnt_d = '0;
      RUN:     cnt_d = at_top ? '0 : cnt_q + CW'(1);
      PAUSE:   cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase

    if (clr_press) begin
      state_d = IDLE;
    end else if (ss_press) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    // Leaving for IDLE restarts the period from zero.
    if (state_d == IDLE) begin
      cnt_d = '0;
    end
  end

  assign EN_TICK = (state_q == RUN) && at_top;
  assign RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Self-checking bench for sw_run_ctrl with TICK_DIV=10, DB_CYCLES=4.
// A behavioural model tracks raw key history, a sliding stability window,
// and the count of RUN cycles since IDLE; outputs are compared every cycle.
module tb_sw_run_ctrl;

  localparam int unsigned TICK_DIV  = 10;
  localparam int unsigned DB_CYCLES = 4;

  logic clk;
  logic rst;
  logic key_ss;
  logic key_clr;
  logic en_tick;
  logic clr_out;
  logic running;

  int n_checks = 0;
  int n_fail   = 0;

  sw_run_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .KEY_SS  (key_ss),
    .KEY_CLR (key_clr),
    .EN_TICK (en_tick),
    .CLR_OUT (clr_out),
    .RUNNING (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

  mstate_t m_st;
  int      m_runidx;
  bit      m_clr_out;
  bit      m_press [2];
  bit      m_db1   [2];
  bit      m_db2   [2];
  bit      m_raw   [2];
  bit      sv_q0   [$];
  bit      sv_q1   [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st      = M_IDLE;
    m_runidx  = 0;
    m_clr_out = 0;
    sv_q0.delete();
    sv_q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_press[k] = 0;
      m_db1[k]   = 1;
      m_db2[k]   = 1;
      m_raw[k]   = 1;
    end
    for (int i = 0; i < int'(DB_CYCLES); i++) begin
      sv_q0.push_back(1'b1);
      sv_q1.push_back(1'b1);
    end
  endtask

  // True when the last DB_CYCLES synchronized samples all disagree with cur.
  function automatic bit window_differs(input int k, input bit cur);
    bit r;
    r = 1'b1;
    if (k == 0) begin
      foreach (sv_q0[i]) if (sv_q0[i] == cur) r = 1'b0;
    end else begin
      foreach (sv_q1[i]) if (sv_q1[i] == cur) r = 1'b0;
    end
    return r;
  endfunction

  task automatic model_step(input logic r, input logic kss, input logic kclr);
    bit kin [2];
    bit p_ss;
    bit p_clr;
    bit new_db;
    kin[0] = kss;
    kin[1] = kclr;
    if (!r) begin
      model_reset();
    end else begin
      p_ss  = m_press[0];
      p_clr = m_press[1];
      if (m_st == M_RUN) m_runidx++;
      if (p_clr)      m_st = M_IDLE;
      else if (p_ss)  m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
      if (m_st == M_IDLE) m_runidx = 0;
      m_clr_out = p_clr;
      for (int k = 0; k < 2; k++) begin
        m_press[k] = m_db2[k] & ~m_db1[k];
        new_db = window_differs(k, m_db1[k]) ? ~m_db1[k] : m_db1[k];
        m_db2[k] = m_db1[k];
        m_db1[k] = new_db;
        if (k == 0) begin
          sv_q0.push_back(m_raw[0]);
          void'(sv_q0.pop_front());
        end else begin
          sv_q1.push_back(m_raw[1]);
          void'(sv_q1.pop_front());
        end
        m_raw[k] = kin[k];
      end
    end
  endtask

  // One clock: drive on negedge, sample 1 ns after posedge, compare to model.
  task automatic cyc(input logic r, input logic ss, input logic clr);
    int exp_en;
    @(negedge clk);
    rst     = r;
    key_ss  = ss;
    key_clr = clr;
    @(posedge clk);
    #1;
    model_step(r, ss, clr);
    exp_en = (m_st == M_RUN && (m_runidx % int'(TICK_DIV)) == int'(TICK_DIV) - 1) ? 1 : 0;
    check_eq("en_tick", int'(en_tick), exp_en);
    check_eq("clr_out", int'(clr_out), int'(m_clr_out));
    check_eq("running", int'(running), (m_st == M_RUN) ? 1 : 0);
  endtask

  task automatic release_keys(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit lvl [2];
    int rem [2];

    rst     = 1'b0;
    key_ss  = 1'b1;
    key_clr = 1'b1;
    model_reset();

    // Reset, then SS held from edge 1.
    cyc(1'b0, 1'b1, 1'b1);
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_clr_out", int'(clr_out), 0);
    check_eq("rst_en_tick", int'(en_tick), 0);
    for (int e = 1; e <= 30; e++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (e == 7)             check_eq("ss_run_early", int'(running), 0);
      if (e == 8)             check_eq("ss_run", int'(running), 1);
      if (e == 17 || e == 27) check_eq("ss_tick", int'(en_tick), 1);
      if (e == 16 || e == 18) check_eq("ss_no_tick", int'(en_tick), 0);
    end
    release_keys(10);

    // SS and CLR together from RUN: CLR wins.
    for (int e = 1; e <= 12; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (e == 8) begin
        check_eq("both_clr_out", int'(clr_out), 1);
        check_eq("both_running", int'(running), 0);
      end
      if (e == 9) check_eq("both_clr_once", int'(clr_out), 0);
    end
    release_keys(10);

    // CLR from IDLE still pulses.
    for (int e = 1; e <= 10; e++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (e == 8) check_eq("idle_clr_out", int'(clr_out), 1);
    end
    release_keys(10);

    // RUN, PAUSE, then reset in PAUSE and restart.
    repeat (8) cyc(1'b1, 1'b0, 1'b1);
    release_keys(9);
    repeat (8) cyc(1'b1, 1'b0, 1'b1);
    release_keys(10);
    cyc(1'b0, 1'b1, 1'b1);
    check_eq("midrst_running", int'(running), 0);
    check_eq("midrst_clr_out", int'(clr_out), 0);
    for (int e = 1; e <= 20; e++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (e == 8)  check_eq("restart_run", int'(running), 1);
      if (e == 17) check_eq("restart_tick", int'(en_tick), 1);
    end
    release_keys(10);

    // Press bounce, then stable low: RUN -> PAUSE once.
    repeat (3) begin
      repeat (3) cyc(1'b1, 1'b0, 1'b1);
      repeat (2) cyc(1'b1, 1'b1, 1'b1);
    end
    for (int e = 1; e <= 14; e++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (e == 7) check_eq("bounce_still_run", int'(running), 1);
      if (e == 8) check_eq("bounce_paused", int'(running), 0);
    end
    // Release bounce.
    repeat (3) begin
      repeat (2) cyc(1'b1, 1'b1, 1'b1);
      repeat (2) cyc(1'b1, 1'b0, 1'b1);
    end
    release_keys(12);

    // Random key activity with rare resets.
    lvl[0] = 1; lvl[1] = 1;
    rem[0] = 5; rem[1] = 30;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = ~lvl[k];
          if (lvl[k])
            rem[k] = (k == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 80));
          else if ($urandom_range(0, 2) == 0)
            rem[k] = int'($urandom_range(1, 3));
          else
            rem[k] = int'($urandom_range(4, 14));
        end
        rem[k]--;
      end
      cyc(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, lvl[0], lvl[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
